// File: rtl/keystream_xor_unit.sv
// Stream-cipher byte combiner: requests one key byte per data byte from the
// keystream generator and XORs it in. The same unit encrypts and decrypts.
module keystream_xor_unit #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   request_hash_byte_pulse,
    input  logic [7:0]             hash_byte_in,
    input  logic                   hash_byte_pulse_in,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   clear_err,
    output logic                   timeout_err,
    output logic                   stray_key_err,
    output logic [COUNT_WIDTH-1:0] byte_count
);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT_KEY,
        OUTPUT
    } state_e;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e                 state_q;
    logic [7:0]             data_q;
    logic [7:0]             out_data_q;
    logic                   req_q;
    logic                   out_valid_q;
    logic [15:0]            timer_q;
    logic                   timeout_err_q;
    logic                   stray_err_q;
    logic [COUNT_WIDTH-1:0] count_q;

    logic timeout_hit_d;
    logic timeout_evt_d;
    logic stray_evt_d;

    // A key pulse in the last waiting cycle takes priority over the timeout.
    assign timeout_hit_d = (timer_q == TIMER_LAST);
    assign timeout_evt_d = (state_q == WAIT_KEY) && !hash_byte_pulse_in && timeout_hit_d;
    assign stray_evt_d   = hash_byte_pulse_in && (state_q != WAIT_KEY);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            data_q        <= '0;
            out_data_q    <= '0;
            req_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
            stray_err_q   <= 1'b0;
            count_q       <= '0;
        end else begin
            req_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        req_q   <= 1'b1;
                        state_q <= REQUEST;
                    end
                end
                REQUEST: begin
                    timer_q <= '0;
                    state_q <= WAIT_KEY;
                end
                WAIT_KEY: begin
                    if (hash_byte_pulse_in) begin
                        out_data_q  <= data_q ^ hash_byte_in;
                        out_valid_q <= 1'b1;
                        state_q     <= OUTPUT;
                    end else if (timeout_hit_d) begin
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        count_q     <= count_q + COUNT_WIDTH'(1);
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Sticky flags: a new event in the clearing cycle keeps the flag set.
            timeout_err_q <= (timeout_err_q & ~clear_err) | timeout_evt_d;
            stray_err_q   <= (stray_err_q & ~clear_err) | stray_evt_d;
        end
    end

    assign in_ready                = (state_q == IDLE);
    assign request_hash_byte_pulse = req_q;
    assign out_data                = out_data_q;
    assign out_valid               = out_valid_q;
    assign timeout_err             = timeout_err_q;
    assign stray_key_err           = stray_err_q;
    assign byte_count              = count_q;

endmodule

// File: tb/tb_keystream_xor_unit.sv
// Directed and randomized bench for keystream_xor_unit with a byte-level
// reference model (out = data ^ key, count of delivered bytes, timeout window).
module tb_keystream_xor_unit;

    localparam int TO = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          request_hash_byte_pulse;
    logic [7:0]    hash_byte_in;
    logic          hash_byte_pulse_in;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic          clear_err;
    logic          timeout_err;
    logic          stray_key_err;
    logic [CW-1:0] byte_count;

    int            checks   = 0;
    int            failures = 0;
    int            req_count = 0;
    logic [15:0]   exp_count;

    keystream_xor_unit #(
        .TIMEOUT_CYCLES(TO),
        .COUNT_WIDTH   (CW)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .in_data                (in_data),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .request_hash_byte_pulse(request_hash_byte_pulse),
        .hash_byte_in           (hash_byte_in),
        .hash_byte_pulse_in     (hash_byte_pulse_in),
        .out_data               (out_data),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .clear_err              (clear_err),
        .timeout_err            (timeout_err),
        .stray_key_err          (stray_key_err),
        .byte_count             (byte_count)
    );

    always #5 clk = ~clk;

    // Independent count of request pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && request_hash_byte_pulse) req_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"},  32'(in_ready), 1);
        check({tag, "_req"},       32'(request_hash_byte_pulse), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_data"},  32'(out_data), 0);
        check({tag, "_tmo_err"},   32'(timeout_err), 0);
        check({tag, "_stray_err"}, 32'(stray_key_err), 0);
        check({tag, "_count"},     32'(byte_count), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_count = '0;
    endtask

    // One byte through the unit. dly = edges into WAIT_KEY at which the key
    // pulse is sampled (1..TO); dly > TO leaves the generator silent.
    task automatic send_byte(input logic [7:0] d, input logic [7:0] k, input int dly, input int bp);
        int         req_before;
        logic [7:0] exp;
        req_before = req_count;
        exp        = d ^ k;
        check("idle_in_ready", 32'(in_ready), 1);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        check("req_pulse", 32'(request_hash_byte_pulse), 1);
        check("busy_in_ready", 32'(in_ready), 0);
        tick();
        check("req_single", 32'(request_hash_byte_pulse), 0);
        if (dly <= TO) begin
            repeat (dly - 1) tick();
            check("no_early_out", 32'(out_valid), 0);
            hash_byte_in       = k;
            hash_byte_pulse_in = 1'b1;
            tick();
            hash_byte_pulse_in = 1'b0;
            hash_byte_in       = 8'($urandom);
            check("out_valid", 32'(out_valid), 1);
            check("out_data", 32'(out_data), 32'(exp));
            check("no_tmo_err", 32'(timeout_err), 0);
            repeat (bp) begin
                tick();
                check("bp_valid", 32'(out_valid), 1);
                check("bp_stable", 32'(out_data), 32'(exp));
                check("bp_in_ready", 32'(in_ready), 0);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            exp_count = exp_count + 16'd1;
            check("done_valid", 32'(out_valid), 0);
            check("done_in_ready", 32'(in_ready), 1);
            check("byte_count", 32'(byte_count), 32'(exp_count));
        end else begin
            repeat (TO - 1) tick();
            check("tmo_not_yet", 32'(timeout_err), 0);
            tick();
            check("tmo_err", 32'(timeout_err), 1);
            check("tmo_idle", 32'(in_ready), 1);
            check("tmo_no_out", 32'(out_valid), 0);
            check("tmo_count", 32'(byte_count), 32'(exp_count));
            clear_err = 1'b1;
            tick();
            clear_err = 1'b0;
            check("tmo_cleared", 32'(timeout_err), 0);
        end
        check("one_request", 32'(req_count - req_before), 1);
    endtask

    initial begin
        logic [7:0] pt  [3];
        logic [7:0] ks  [3];
        logic [7:0] ct  [3];
        logic [7:0] ref_ct [3];

        rst                = 1'b1;
        in_data            = '0;
        in_valid           = 1'b0;
        hash_byte_in       = '0;
        hash_byte_pulse_in = 1'b0;
        out_ready          = 1'b0;
        clear_err          = 1'b0;
        exp_count          = '0;
        tick();
        tick();
        check_reset_state("reset");
        rst = 1'b0;

        // Single byte, key arrives on the third WAIT_KEY edge.
        send_byte(8'hA5, 8'h3C, 3, 2);
        check("single_const", 32'(out_data), 32'h99);
        check("single_count", 32'(byte_count), 1);

        // Round trip: encrypt then decrypt with the same keys.
        do_reset();
        pt[0] = 8'h00; pt[1] = 8'hFF; pt[2] = 8'h5A;
        ks[0] = 8'h11; ks[1] = 8'h22; ks[2] = 8'h33;
        ref_ct[0] = 8'h11; ref_ct[1] = 8'hDD; ref_ct[2] = 8'h69;
        for (int i = 0; i < 3; i++) begin
            send_byte(pt[i], ks[i], 1 + i, 0);
            check("enc_const", 32'(out_data), 32'(ref_ct[i]));
            ct[i] = pt[i] ^ ks[i];
        end
        for (int i = 0; i < 3; i++) begin
            send_byte(ct[i], ks[i], 2, 1);
            check("dec_restore", 32'(out_data), 32'(pt[i]));
        end
        check("roundtrip_count", 32'(byte_count), 6);

        // Backpressure for ten cycles.
        send_byte(8'hC3, 8'h0F, 2, 10);

        // Silent generator: timeout after TO cycles in WAIT_KEY.
        send_byte(8'h77, 8'h00, TO + 1, 0);

        // Stray key pulse in IDLE, then a byte using only the later key.
        hash_byte_in       = 8'hEE;
        hash_byte_pulse_in = 1'b1;
        tick();
        hash_byte_pulse_in = 1'b0;
        check("stray_set", 32'(stray_key_err), 1);
        send_byte(8'h42, 8'h81, 2, 0);
        check("stray_key_ignored", 32'(out_data), 32'h42 ^ 32'h81);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("stray_cleared", 32'(stray_key_err), 0);

        // Clear and a new stray event in the same cycle: set wins.
        clear_err          = 1'b1;
        hash_byte_pulse_in = 1'b1;
        tick();
        clear_err          = 1'b0;
        hash_byte_pulse_in = 1'b0;
        check("set_wins", 32'(stray_key_err), 1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;

        // Key pulse on the final timeout cycle is processed.
        send_byte(8'h1E, 8'hE1, TO, 0);

        // Reset while waiting for the key.
        in_data  = 8'h55;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        do_reset();
        check_reset_state("rst_wait");

        // Reset while holding output.
        in_data  = 8'h66;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        hash_byte_in       = 8'h99;
        hash_byte_pulse_in = 1'b1;
        tick();
        hash_byte_pulse_in = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 1);
        do_reset();
        check_reset_state("rst_out");
        send_byte(8'h3A, 8'hA3, 1, 0);
        check("post_rst_count", 32'(byte_count), 1);

        // Randomized traffic against the byte-level model.
        for (int i = 0; i < 24; i++) begin
            send_byte(8'($urandom), 8'($urandom), int'($urandom_range(1, TO + 1)),
                      int'($urandom_range(0, 3)));
        end
        check("stray_quiet", 32'(stray_key_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keystream_xor_unit.md
Name: keystream_xor_unit

Overview:
- Consumer end of the keystream byte interface. Accepts one data byte at a time over a valid/ready handshake.
- For each byte it sends a single-cycle request pulse to the hash/keystream generator and waits for the generator's key-byte pulse. It then XORs the data byte with the key byte and presents the result over a valid/ready handshake.
- Encryption and decryption are the same operation, so one instance serves either direction of the stream cipher path.

Parameters:
- TIMEOUT_CYCLES, 64, number of cycles in WAIT_KEY with no key pulse before the byte is abandoned; legal range 2..65535.
- COUNT_WIDTH, 16, width of the processed-byte counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_data  in  8  plaintext or ciphertext byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  unit can accept a byte.
- request_hash_byte_pulse  out  1  one-cycle request to the keystream generator.
- hash_byte_in  in  8  key byte from the generator; sampled only when hash_byte_pulse_in=1.
- hash_byte_pulse_in  in  1  one-cycle key-byte-valid strobe from the generator.
- out_data  out  8  in_data XOR key byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- clear_err  in  1  clears both sticky error flags.
- timeout_err  out  1  sticky; set when a key byte was not received within TIMEOUT_CYCLES.
- stray_key_err  out  1  sticky; set when a key pulse arrives outside WAIT_KEY.
- byte_count  out  COUNT_WIDTH  number of bytes delivered downstream.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - in_ready=1 (combinational from state), request_hash_byte_pulse=0, out_valid=0, out_data=0.
  - timeout_err=0, stray_key_err=0, byte_count=0.
  - Internal data latch and timeout counter cleared.
  - Reset mid-operation discards any held byte and any pending request.
- State machine states: IDLE, REQUEST, WAIT_KEY, OUTPUT.
- IDLE:
  - in_ready=1.
  - When in_valid=1, latch in_data and go to REQUEST.
- REQUEST:
  - request_hash_byte_pulse=1 for exactly this one cycle; the output is registered and driven high only while in REQUEST.
  - Go unconditionally to WAIT_KEY; timeout counter loads 0.
- WAIT_KEY:
  - If hash_byte_pulse_in=1: out_data <= latched byte XOR hash_byte_in, then go to OUTPUT.
  - Otherwise the timeout counter increments.
  - If the counter equals TIMEOUT_CYCLES-1 with no pulse: set timeout_err, drop the byte, go to IDLE. No output is produced and byte_count is unchanged.
  - A pulse in the same cycle the timeout would fire wins: the byte is processed and no error is raised.
- OUTPUT:
  - out_valid=1; out_data is held stable until out_ready=1.
  - On out_valid & out_ready: byte_count increments (wraps from all-ones to 0) and the unit returns to IDLE.
  - The next byte can be accepted no earlier than the following cycle; there is no bypass.
- in_ready is 0 in every state other than IDLE.
- Latency:
  - Byte accepted at edge N → request pulse high during cycle N+1.
  - Key pulse sampled at edge K → out_valid high from cycle K+1.
  - Minimum turnaround per byte is 4 cycles plus the generator's response time.
- Stray key pulses:
  - hash_byte_pulse_in=1 in IDLE, REQUEST or OUTPUT sets stray_key_err.
  - The stray key byte is ignored and never used for a later byte.
- Errors:
  - clear_err=1 clears both flags that cycle.
  - If clear_err and a new error event coincide, the flag is set (set wins).
- Only one request is ever outstanding; a second request is never issued before a key pulse or a timeout.

Test Plan:
1. Single byte: reset; in_data=8'hA5, in_valid=1; generator pulses hash_byte_in=8'h3C 3 cycles after the request → exactly one request pulse; out_data=8'h99, out_valid until out_ready; byte_count=1.
2. Round trip: encrypt 8'h00, 8'hFF, 8'h5A with key bytes 8'h11, 8'h22, 8'h33, then decrypt the outputs with the same keys → outputs 8'h11, 8'hDD, 8'h69, then the original bytes restored; byte_count=6.
3. Backpressure: hold out_ready=0 for 10 cycles in OUTPUT → out_data stable; in_ready=0; no extra request pulse; a later out_ready=1 completes with a single count increment.
4. Timeout: TIMEOUT_CYCLES=4, generator silent → timeout_err=1 exactly 4 cycles after entering WAIT_KEY; state IDLE; no out_valid; byte_count unchanged; clear_err clears the flag.
5. Stray pulse and edge cases: key pulse in IDLE → stray_key_err=1 and the next byte uses only the later key. Key pulse on the final timeout cycle → byte processed, timeout_err=0.
6. Reset mid-operation: assert rst in WAIT_KEY and in OUTPUT → next cycle all outputs at reset values; a subsequent byte is processed normally with byte_count counting from 0.
